// File: rtl/argmax_engine.sv
`default_nettype none
// ============================================================================
// Module   : argmax_engine
// Brief    : Streams FEATURE_ROWS rows and writes each row's argmax class index.
// Revision : 1.0
// ============================================================================

module argmax_engine #(
    parameter int FEATURE_ROWS   = 6,
    parameter int WEIGHT_COLS    = 3,
    parameter int DATA_WIDTH     = 16,
    parameter int SIGNED_DATA    = 1,
    parameter int ROW_ADDR_WIDTH = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
    parameter int IDX_WIDTH      = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    output logic                              read_enable,
    output logic [ROW_ADDR_WIDTH-1:0]         read_addr,
    input  logic [WEIGHT_COLS*DATA_WIDTH-1:0] read_data,
    output logic                              write_enable,
    output logic [ROW_ADDR_WIDTH-1:0]         write_addr,
    output logic [IDX_WIDTH-1:0]              write_data,
    output logic [DATA_WIDTH-1:0]             max_value,
    output logic                              busy,
    output logic                              done
);

    localparam logic [ROW_ADDR_WIDTH-1:0] c_LAST_ROW = ROW_ADDR_WIDTH'(FEATURE_ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [ROW_ADDR_WIDTH-1:0] r_row;
    logic                      r_drain;
    logic                      r_rd_valid;
    logic [ROW_ADDR_WIDTH-1:0] r_rd_addr;
    logic                      r_wr_en;
    logic [ROW_ADDR_WIDTH-1:0] r_wr_addr;
    logic [IDX_WIDTH-1:0]      r_wr_idx;
    logic [DATA_WIDTH-1:0]     r_wr_max;
    logic [IDX_WIDTH-1:0]      w_idx;
    logic [DATA_WIDTH-1:0]     w_max;

    function automatic logic f_gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        if (SIGNED_DATA != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_READ;
            S_READ:  if (r_row == c_LAST_ROW) w_next_state = S_DRAIN;
            S_DRAIN: if (r_drain) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Row counter parks on the last row so read_addr never wraps past it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row   <= '0;
            r_drain <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_row   <= '0;
                    r_drain <= 1'b0;
                end
                S_READ: begin
                    if (r_row != c_LAST_ROW) begin
                        r_row <= r_row + ROW_ADDR_WIDTH'(1);
                    end
                end
                S_DRAIN: r_drain <= ~r_drain;
                default: r_drain <= 1'b0;
            endcase
        end
    end

    // Ties keep the earliest column because only a strictly larger element wins.
    always_comb begin
        w_max = read_data[DATA_WIDTH-1:0];
        w_idx = '0;
        for (int c = 1; c < WEIGHT_COLS; c++) begin
            if (f_gt(read_data[c*DATA_WIDTH +: DATA_WIDTH], w_max)) begin
                w_max = read_data[c*DATA_WIDTH +: DATA_WIDTH];
                w_idx = IDX_WIDTH'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_addr  <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_idx   <= '0;
            r_wr_max   <= '0;
        end else begin
            r_rd_valid <= read_enable;
            r_rd_addr  <= read_addr;
            r_wr_en    <= r_rd_valid;
            if (r_rd_valid) begin
                r_wr_addr <= r_rd_addr;
                r_wr_idx  <= w_idx;
                r_wr_max  <= w_max;
            end
        end
    end

    assign read_enable  = (r_state == S_READ);
    assign read_addr    = r_row;
    assign write_enable = r_wr_en;
    assign write_addr   = r_wr_addr;
    assign write_data   = r_wr_idx;
    assign max_value    = r_wr_max;
    assign busy         = (r_state == S_READ) || (r_state == S_DRAIN);
    assign done         = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_argmax_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_argmax_engine
// Brief    : Scoreboard bench for argmax_engine across four parameter sets.
// Revision : 1.0
// ============================================================================

module tb_argmax_engine;

    typedef struct packed {
        logic [7:0]  addr;
        logic [7:0]  idx;
        logic [15:0] mx;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    exp_t qd[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A: 6x3 signed, B: 6x3 unsigned, C: 1x1, D: 8x5
    logic        a_start, a_re, a_we, a_busy, a_done;
    logic [2:0]  a_ra, a_wa;
    logic [1:0]  a_wd;
    logic [15:0] a_mx;
    logic [47:0] a_rd;

    logic        b_start, b_re, b_we, b_busy, b_done;
    logic [2:0]  b_ra, b_wa;
    logic [1:0]  b_wd;
    logic [15:0] b_mx;
    logic [47:0] b_rd;

    logic        c_start, c_re, c_we, c_busy, c_done;
    logic [0:0]  c_ra, c_wa;
    logic [0:0]  c_wd;
    logic [15:0] c_mx;
    logic [15:0] c_rd;

    logic        d_start, d_re, d_we, d_busy, d_done;
    logic [2:0]  d_ra, d_wa;
    logic [2:0]  d_wd;
    logic [15:0] d_mx;
    logic [79:0] d_rd;

    logic [47:0] mem_s [6];
    logic [79:0] mem_d [8];

    argmax_engine #(.FEATURE_ROWS(6), .WEIGHT_COLS(3), .DATA_WIDTH(16), .SIGNED_DATA(1)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .read_enable(a_re), .read_addr(a_ra),
        .read_data(a_rd), .write_enable(a_we), .write_addr(a_wa), .write_data(a_wd),
        .max_value(a_mx), .busy(a_busy), .done(a_done));

    argmax_engine #(.FEATURE_ROWS(6), .WEIGHT_COLS(3), .DATA_WIDTH(16), .SIGNED_DATA(0)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .read_enable(b_re), .read_addr(b_ra),
        .read_data(b_rd), .write_enable(b_we), .write_addr(b_wa), .write_data(b_wd),
        .max_value(b_mx), .busy(b_busy), .done(b_done));

    argmax_engine #(.FEATURE_ROWS(1), .WEIGHT_COLS(1), .DATA_WIDTH(16), .SIGNED_DATA(1)) u_c (
        .clk(clk), .reset(reset), .start(c_start), .read_enable(c_re), .read_addr(c_ra),
        .read_data(c_rd), .write_enable(c_we), .write_addr(c_wa), .write_data(c_wd),
        .max_value(c_mx), .busy(c_busy), .done(c_done));

    argmax_engine #(.FEATURE_ROWS(8), .WEIGHT_COLS(5), .DATA_WIDTH(16), .SIGNED_DATA(1)) u_d (
        .clk(clk), .reset(reset), .start(d_start), .read_enable(d_re), .read_addr(d_ra),
        .read_data(d_rd), .write_enable(d_we), .write_addr(d_wa), .write_data(d_wd),
        .max_value(d_mx), .busy(d_busy), .done(d_done));

    // Result memories: one-cycle read latency
    always @(posedge clk) begin
        if (a_re) a_rd <= mem_s[a_ra];
        if (b_re) b_rd <= mem_s[b_ra];
        if (c_re) c_rd <= 16'h8000;
        if (d_re) d_rd <= mem_d[d_ra];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_wr(input string nm, input exp_t e, input logic [7:0] a,
                          input logic [7:0] d, input logic [15:0] m);
        chk({nm, ".addr"}, 32'(a), 32'(e.addr));
        chk({nm, ".idx"},  32'(d), 32'(e.idx));
        chk({nm, ".max"},  32'(m), 32'(e.mx));
    endtask

    task automatic unexpected(input string nm, input logic [7:0] a);
        n_vec++;
        n_err++;
        $display("FAIL %s unexpected write: got addr %0d expected no write at %0t", nm, a, $time);
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_we) begin
            if (qa.size() == 0) unexpected("A", 8'(a_wa));
            else begin e = qa.pop_front(); chk_wr("A", e, 8'(a_wa), 8'(a_wd), a_mx); end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_we) begin
            if (qb.size() == 0) unexpected("B", 8'(b_wa));
            else begin e = qb.pop_front(); chk_wr("B", e, 8'(b_wa), 8'(b_wd), b_mx); end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (c_we) begin
            if (qc.size() == 0) unexpected("C", 8'(c_wa));
            else begin e = qc.pop_front(); chk_wr("C", e, 8'(c_wa), 8'(c_wd), c_mx); end
        end
    end

    always @(negedge clk) begin : mon_d
        exp_t e;
        if (d_we) begin
            if (qd.size() == 0) unexpected("D", 8'(d_wa));
            else begin e = qd.pop_front(); chk_wr("D", e, 8'(d_wa), 8'(d_wd), d_mx); end
        end
    end

    function automatic logic [47:0] pack3(input logic [15:0] c0, input logic [15:0] c1,
                                          input logic [15:0] c2);
        return {c2, c1, c0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_signed();
        qa.push_back('{8'd0, 8'd1, 16'd9});
        qa.push_back('{8'd1, 8'd0, 16'hFFFF});
        qa.push_back('{8'd2, 8'd0, 16'd7});
        qa.push_back('{8'd3, 8'd0, 16'd0});
        qa.push_back('{8'd4, 8'd1, 16'd4});
        qa.push_back('{8'd5, 8'd2, 16'd3});
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, ".read_enable"},  32'(a_re),   32'd0);
        chk({tag, ".read_addr"},    32'(a_ra),   32'd0);
        chk({tag, ".write_enable"}, 32'(a_we),   32'd0);
        chk({tag, ".write_addr"},   32'(a_wa),   32'd0);
        chk({tag, ".write_data"},   32'(a_wd),   32'd0);
        chk({tag, ".max_value"},    32'(a_mx),   32'd0);
        chk({tag, ".busy"},         32'(a_busy), 32'd0);
        chk({tag, ".done"},         32'(a_done), 32'd0);
    endtask

    initial begin
        int n_done;
        int n_reads;
        int max_ra;
        logic [79:0] w;

        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0; d_start = 1'b0;

        mem_s[0] = pack3(16'd5,      16'd9,      16'd2);
        mem_s[1] = pack3(16'hFFFF,   16'hFFFD,   16'hFFFE);
        mem_s[2] = pack3(16'd7,      16'd7,      16'd1);
        mem_s[3] = pack3(16'd0,      16'd0,      16'd0);
        mem_s[4] = pack3(16'hFFF8,   16'd4,      16'd4);
        mem_s[5] = pack3(16'd1,      16'd2,      16'd3);
        for (int r = 0; r < 7; r++) begin
            w = '0;
            w[(r % 5)*16 +: 16] = 16'(100 + r);
            mem_d[r] = w;
        end
        mem_d[7] = {16'd1, 16'd9, 16'd9, 16'd3, 16'd3};

        repeat (3) tick();
        reset = 1'b0;
        chk_a_zero("reset");

        // Signed run with cycle-accurate timeline checks
        push_signed();
        a_start = 1'b1;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            tick();
            a_start = 1'b0;
            chk("run1.busy",  32'(a_busy), 32'((cyc >= 1) && (cyc <= 8)));
            chk("run1.done",  32'(a_done), 32'(cyc == 9));
            chk("run1.we",    32'(a_we),   32'((cyc >= 3) && (cyc <= 8)));
            chk("run1.re",    32'(a_re),   32'((cyc >= 1) && (cyc <= 6)));
            if (cyc <= 6) chk("run1.read_addr", 32'(a_ra), 32'(cyc - 1));
        end

        // Reset in cycle 4 aborts the run after rows 0 and 1 were written
        qa.push_back('{8'd0, 8'd1, 16'd9});
        qa.push_back('{8'd1, 8'd0, 16'hFFFF});
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_a_zero("abort");
        for (int cyc = 6; cyc <= 12; cyc++) begin
            tick();
            chk("abort.we",   32'(a_we),   32'd0);
            chk("abort.busy", 32'(a_busy), 32'd0);
        end

        // start held high: exactly two back-to-back runs
        push_signed();
        push_signed();
        n_done = 0;
        a_start = 1'b1;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            tick();
            if (cyc == 11) a_start = 1'b0;
            if (a_done) n_done++;
            chk("held.done", 32'(a_done), 32'((cyc == 9) || (cyc == 19)));
            chk("held.we",   32'(a_we),   32'(((cyc >= 3) && (cyc <= 8)) || ((cyc >= 13) && (cyc <= 18))));
        end
        chk("held.n_done", 32'(n_done), 32'd2);

        // Unsigned comparison on the same data
        qb.push_back('{8'd0, 8'd1, 16'd9});
        qb.push_back('{8'd1, 8'd0, 16'hFFFF});
        qb.push_back('{8'd2, 8'd0, 16'd7});
        qb.push_back('{8'd3, 8'd0, 16'd0});
        qb.push_back('{8'd4, 8'd0, 16'hFFF8});
        qb.push_back('{8'd5, 8'd2, 16'd3});
        b_start = 1'b1;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            tick();
            b_start = 1'b0;
            chk("unsigned.done", 32'(b_done), 32'(cyc == 9));
        end

        // Single row, single column
        qc.push_back('{8'd0, 8'd0, 16'h8000});
        c_start = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            tick();
            c_start = 1'b0;
            chk("one.done", 32'(c_done), 32'(cyc == 4));
            chk("one.we",   32'(c_we),   32'(cyc == 3));
            chk("one.busy", 32'(c_busy), 32'((cyc >= 1) && (cyc <= 3)));
        end

        // 8x5 with a tie on the maximum in the last row
        for (int r = 0; r < 7; r++) qd.push_back('{8'(r), 8'(r % 5), 16'(100 + r)});
        qd.push_back('{8'd7, 8'd2, 16'd9});
        n_reads = 0;
        max_ra = 0;
        d_start = 1'b1;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            tick();
            d_start = 1'b0;
            if (d_re) begin
                n_reads++;
                if (int'(d_ra) > max_ra) max_ra = int'(d_ra);
            end
            chk("wide.done", 32'(d_done), 32'(cyc == 11));
        end
        chk("wide.n_reads", 32'(n_reads), 32'd8);
        chk("wide.max_addr", 32'(max_ra), 32'd7);

        repeat (4) tick();
        chk("A.pending", 32'(qa.size()), 32'd0);
        chk("B.pending", 32'(qb.size()), 32'd0);
        chk("C.pending", 32'(qc.size()), 32'd0);
        chk("D.pending", 32'(qd.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/argmax_engine.md
Name: argmax_engine

Overview:
- Parametrised argmax stage at the tail of the GCN pipeline.
- Streams every row of the output feature matrix (FEATURE_ROWS x WEIGHT_COLS) from the result memory.
- Per row, finds the column index of the maximum element and writes that class index to the argmax memory.
- Replaces the fixed 6-row sequencer: it generalises row/column count, data width and signedness, computes the argmax itself, and can re-run after completion.

Parameters:
- FEATURE_ROWS, 6, number of rows (nodes) to classify; must be >= 1.
- WEIGHT_COLS, 3, elements per row (classes); must be >= 1.
- DATA_WIDTH, 16, width of one matrix element.
- SIGNED_DATA, 1, 1 = elements compared as two's complement; 0 = unsigned.
- ROW_ADDR_WIDTH, $clog2(FEATURE_ROWS) (min 1), width of row addresses.
- IDX_WIDTH, $clog2(WEIGHT_COLS) (min 1), width of a class index.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  run request, sampled only in IDLE.
- read_enable  output  1  result-memory read strobe.
- read_addr  output  ROW_ADDR_WIDTH  row being read.
- read_data  input  WEIGHT_COLS*DATA_WIDTH  row data, valid exactly 1 cycle after read_enable; column c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- write_enable  output  1  argmax-memory write strobe.
- write_addr  output  ROW_ADDR_WIDTH  row index being written.
- write_data  output  IDX_WIDTH  argmax column index.
- max_value  output  DATA_WIDTH  maximum element of the row being written; valid with write_enable.
- busy  output  1  high in READ and DRAIN.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All outputs are 0: read_enable, read_addr, write_enable, write_addr, write_data, max_value, busy, done.
  - Row counter and pipeline valid bits clear; in-flight reads and writes are discarded.
  - Reset asserted mid-run aborts the run; no further writes occur.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: start=1 -> READ next cycle with row counter 0; otherwise stay.
  - READ: read_enable=1, read_addr=row counter, counter increments each cycle. When counter==FEATURE_ROWS-1 -> DRAIN.
  - DRAIN: 2 cycles, no reads, lets the pipeline empty -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- start is ignored outside IDLE. start held high through DONE launches a new run from the IDLE cycle that follows.
- Pipeline, for the read of row r issued in cycle t:
  - t+1: read_data valid; combinational argmax over WEIGHT_COLS elements; result registered.
  - t+2: write_enable=1, write_addr=r, write_data=index, max_value=max.
  - Read-to-write latency is 2 cycles. Throughput is one row per cycle with no bubbles.
- Timeline, start sampled high in IDLE at cycle 0 (N=FEATURE_ROWS):
  - Cycles 1..N: READ.
  - Cycles N+1..N+2: DRAIN.
  - Writes occur in cycles 3..N+2.
  - Cycle N+3: DONE, done=1.
  - Cycle N+4: IDLE.
- Compare rules:
  - SIGNED_DATA selects signed or unsigned comparison.
  - Ties resolve to the lowest column index (strict greater-than replaces the running max).
  - WEIGHT_COLS=1 always yields index 0.
- write_enable is low whenever no valid pipelined row exists; write_addr and write_data hold their last values when write_enable is low.
- FEATURE_ROWS=1: READ lasts one cycle, then DRAIN.

Test Plan:
- Reset, then start pulse, N=6, C=3, W=16 signed; rows {5,9,2},{-1,-3,-2},{7,7,1},{0,0,0},{-8,4,4},{1,2,3} -> writes addr0..5 data 1,0,0,0,1,2, max_value 9,-1,7,0,4,3; writes in cycles 3..8, done=1 only in cycle 9, busy=1 in cycles 1..8.
- Same data, SIGNED_DATA=0 -> row1 {0xFFFF,0xFFFD,0xFFFE} gives index 0; row4 {0xFFF8,4,4} gives index 0, max 0xFFF8.
- Assert reset in cycle 4 of a run -> from the next cycle all outputs 0 and state IDLE; no write_enable afterwards until a new start.
- Hold start=1 continuously -> back-to-back runs, each with exactly 6 writes and one done pulse; start pulses during READ or DRAIN are ignored, with no double run.
- FEATURE_ROWS=1, WEIGHT_COLS=1, row {0x8000} -> single write, addr 0, data 0, max 0x8000; done in cycle 4.
- FEATURE_ROWS=8, WEIGHT_COLS=5, row 7 = {3,3,9,9,1} -> write addr 7, data 2; read_addr reaches 7 with no wrap or extra read.
